// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: captures fetched {PC, instruction} pairs and presents the oldest to ID (FWFT).
// Optional IFQ_PERF_CNT_EN adds saturating bubble and flush-drop performance counters.
module if_id_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       fetch_valid_i,
    input  logic [31:0]                pc_i,
    input  logic [31:0]                instr_i,
    output logic                       fetch_ready_o,
    input  logic                       stall_i,
    input  logic                       cpu_stall_i,
    input  logic                       flush_i,
    output logic                       valid_o,
    output logic [31:0]                pc_o,
    output logic [31:0]                instr_o,
`ifdef IFQ_PERF_CNT_EN
    output logic [31:0]                bubble_cnt_o,
    output logic [31:0]                flush_drop_cnt_o,
`endif
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Ready depends only on occupancy, never on this cycle's pop, to keep PC-enable timing short.
    assign fetch_ready_o = rst_n_i & ~cpu_stall_i & (count < FULL);
    assign valid_o       = (count != '0);
    assign push          = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign pop           = valid_o & ~stall_i & ~cpu_stall_i & ~flush_i;

    assign pc_o    = valid_o ? pc_mem[rd_ptr]    : 32'h0;
    assign instr_o = valid_o ? instr_mem[rd_ptr] : NOP_INSTR;
    assign count_o = count;

    // NOTE: storage has no reset; entries are only observable once count marks them valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc_i;
            instr_mem[wr_ptr] <= instr_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (cpu_stall_i) begin
            rd_ptr <= rd_ptr;
        end else if (flush_i) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef IFQ_PERF_CNT_EN
    logic        bubble;
    logic [32:0] drop_sum;

    assign bubble   = ~valid_o & ~stall_i & ~cpu_stall_i & ~flush_i;
    assign drop_sum = {1'b0, flush_drop_cnt_o} + 33'(count);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bubble_cnt_o     <= '0;
            flush_drop_cnt_o <= '0;
        end else begin
            if (bubble && bubble_cnt_o != '1)
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
            if (flush_i && !cpu_stall_i)
                flush_drop_cnt_o <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end
`endif

endmodule
